// File: rtl/fmul_front_r4.sv
// -----------------------------------------------------------------------------
// fmul_front_r4
// Front end of a single-precision fused multiply-add. Two register stages:
//   S1 decodes a and b (sign, exponent, significand, NaN/inf/zero/subnormal)
//      and captures op_c, fma_op, rm_i, rd_i and p_start.
//   S2 forms the 24x24 significand product, the biased product exponent,
//      the product sign and the product class for the downstream adder.
//
// Build option:
//   FMUL_FRONT_SUBNORM_EN  defined   : subnormals use hidden bit 0, exponent 1
//                          undefined : subnormals are treated as signed zero
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  advance enable (0 holds every stage)
//   clear[1:0]          per-stage flush, bit0 = S1, bit1 = S2
//   p_start             operation valid for the operands sampled this cycle
//   op_a, op_b, op_c    IEEE-754 single operands, result is a*b +/- c
//   fma_op              00 fmadd, 01 fmsub, 10 fnmsub, 11 fnmadd
//   rm_i, rd_i          rounding mode and destination register
//   num1_*              product exponent, significand, sign and class
//   num2, add_sub       op_c passthrough and add(0)/subtract(1) select
//   rm_o, rd_o          rounding mode and destination register at S2
//   p_result, invalid   output valid, inf*0 detected
//   uu_rd[0:1]          destination register held in S1 and S2
// -----------------------------------------------------------------------------
module fmul_front_r4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  clear,
  input  logic        p_start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] op_c,
  input  logic [1:0]  fma_op,
  input  logic [2:0]  rm_i,
  input  logic [4:0]  rd_i,
  output logic [9:0]  num1_exp,
  output logic [47:0] num1_mant,
  output logic        num1_sign,
  output logic        num1_is_NaN,
  output logic        num1_is_inf,
  output logic        num1_is_zero,
  output logic [31:0] num2,
  output logic        add_sub,
  output logic [2:0]  rm_o,
  output logic [4:0]  rd_o,
  output logic        p_result,
  output logic        invalid,
  output logic [4:0]  uu_rd [0:1]
);

  // Operand field decode (combinational, feeds S1)
  logic       w_a_exp_max, w_a_exp_zero, w_a_frac_nz;
  logic       w_b_exp_max, w_b_exp_zero, w_b_frac_nz;

  assign w_a_exp_max  = &op_a[30:23];
  assign w_a_exp_zero = ~|op_a[30:23];
  assign w_a_frac_nz  = |op_a[22:0];
  assign w_b_exp_max  = &op_b[30:23];
  assign w_b_exp_zero = ~|op_b[30:23];
  assign w_b_frac_nz  = |op_b[22:0];

  // S1 registers
  logic        r_s1_valid;
  logic        r_a_sign, r_b_sign;
  logic [7:0]  r_a_exp, r_b_exp;
  logic [23:0] r_a_sig, r_b_sig;
  logic        r_a_nan, r_a_inf, r_a_zero, r_a_sub;
  logic        r_b_nan, r_b_inf, r_b_zero, r_b_sub;
  logic [31:0] r_s1_c;
  logic [1:0]  r_s1_fma;
  logic [2:0]  r_s1_rm;
  logic [4:0]  r_s1_rd;

  // S1: capture decoded operands. The hidden bit is simply "exponent nonzero",
  // so subnormals already carry a 0 hidden bit here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a_sign <= 1'b0; r_b_sign <= 1'b0;
      r_a_exp  <= '0;   r_b_exp  <= '0;
      r_a_sig  <= '0;   r_b_sig  <= '0;
      r_a_nan  <= 1'b0; r_a_inf  <= 1'b0; r_a_zero <= 1'b0; r_a_sub <= 1'b0;
      r_b_nan  <= 1'b0; r_b_inf  <= 1'b0; r_b_zero <= 1'b0; r_b_sub <= 1'b0;
      r_s1_c   <= '0;   r_s1_fma <= '0;   r_s1_rm  <= '0;   r_s1_rd <= '0;
    end else if (clear[0]) begin
      r_s1_valid <= 1'b0;
      r_a_sign <= 1'b0; r_b_sign <= 1'b0;
      r_a_exp  <= '0;   r_b_exp  <= '0;
      r_a_sig  <= '0;   r_b_sig  <= '0;
      r_a_nan  <= 1'b0; r_a_inf  <= 1'b0; r_a_zero <= 1'b0; r_a_sub <= 1'b0;
      r_b_nan  <= 1'b0; r_b_inf  <= 1'b0; r_b_zero <= 1'b0; r_b_sub <= 1'b0;
      r_s1_c   <= '0;   r_s1_fma <= '0;   r_s1_rm  <= '0;   r_s1_rd <= '0;
    end else if (en) begin
      r_s1_valid <= p_start;
      r_a_sign <= op_a[31];
      r_b_sign <= op_b[31];
      r_a_exp  <= op_a[30:23];
      r_b_exp  <= op_b[30:23];
      r_a_sig  <= {~w_a_exp_zero, op_a[22:0]};
      r_b_sig  <= {~w_b_exp_zero, op_b[22:0]};
      r_a_nan  <= w_a_exp_max & w_a_frac_nz;
      r_a_inf  <= w_a_exp_max & ~w_a_frac_nz;
      r_a_zero <= w_a_exp_zero & ~w_a_frac_nz;
      r_a_sub  <= w_a_exp_zero & w_a_frac_nz;
      r_b_nan  <= w_b_exp_max & w_b_frac_nz;
      r_b_inf  <= w_b_exp_max & ~w_b_frac_nz;
      r_b_zero <= w_b_exp_zero & ~w_b_frac_nz;
      r_b_sub  <= w_b_exp_zero & w_b_frac_nz;
      r_s1_c   <= op_c;
      r_s1_fma <= fma_op;
      r_s1_rm  <= rm_i;
      r_s1_rd  <= rd_i;
    end
  end

  // Subnormal handling: either an effective exponent of 1, or fold into zero
  logic [7:0] w_a_eff, w_b_eff;
  logic       w_a_zcls, w_b_zcls;
`ifdef FMUL_FRONT_SUBNORM_EN
  assign w_a_eff  = r_a_sub ? 8'd1 : r_a_exp;
  assign w_b_eff  = r_b_sub ? 8'd1 : r_b_exp;
  assign w_a_zcls = r_a_zero;
  assign w_b_zcls = r_b_zero;
`else
  assign w_a_eff  = r_a_exp;
  assign w_b_eff  = r_b_exp;
  assign w_a_zcls = r_a_zero | r_a_sub;
  assign w_b_zcls = r_b_zero | r_b_sub;
`endif

  // Product class, priority NaN > inf > zero; inf*0 is an invalid NaN
  logic        w_inv, w_nan, w_inf, w_zero;
  logic [47:0] w_prod;
  logic [9:0]  w_exp;

  assign w_inv  = (r_a_inf & w_b_zcls) | (w_a_zcls & r_b_inf);
  assign w_nan  = r_a_nan | r_b_nan | w_inv;
  assign w_inf  = (r_a_inf | r_b_inf) & ~w_nan;
  assign w_zero = (w_a_zcls | w_b_zcls) & ~w_nan & ~w_inf;
  assign w_prod = {24'd0, r_a_sig} * {24'd0, r_b_sig};
  // 10-bit two's complement, wraps freely so underflow stays visible downstream
  assign w_exp  = {2'b00, w_a_eff} + {2'b00, w_b_eff} - 10'd127;

  // S2: product stage, drives the outputs directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_result <= 1'b0; invalid <= 1'b0;
      num1_exp <= '0; num1_mant <= '0; num1_sign <= 1'b0;
      num1_is_NaN <= 1'b0; num1_is_inf <= 1'b0; num1_is_zero <= 1'b0;
      num2 <= '0; add_sub <= 1'b0; rm_o <= '0; rd_o <= '0;
    end else if (clear[1]) begin
      p_result <= 1'b0; invalid <= 1'b0;
      num1_exp <= '0; num1_mant <= '0; num1_sign <= 1'b0;
      num1_is_NaN <= 1'b0; num1_is_inf <= 1'b0; num1_is_zero <= 1'b0;
      num2 <= '0; add_sub <= 1'b0; rm_o <= '0; rd_o <= '0;
    end else if (en) begin
      p_result     <= r_s1_valid;
      invalid      <= w_inv;
      num1_exp     <= w_zero ? 10'd0 : w_exp;
      num1_mant    <= w_zero ? 48'd0 : w_prod;
      num1_sign    <= r_a_sign ^ r_b_sign ^ r_s1_fma[1];
      num1_is_NaN  <= w_nan;
      num1_is_inf  <= w_inf;
      num1_is_zero <= w_zero;
      num2         <= r_s1_c;
      add_sub      <= r_s1_fma[0];
      rm_o         <= r_s1_rm;
      rd_o         <= r_s1_rd;
    end
  end

  assign uu_rd[0] = r_s1_rd;
  assign uu_rd[1] = rd_o;

endmodule

// File: tb/tb_fmul_front_r4.sv
// Directed bench for fmul_front_r4 with hand-computed expected values.
module tb_fmul_front_r4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  clear;
  logic        p_start;
  logic [31:0] op_a, op_b, op_c;
  logic [1:0]  fma_op;
  logic [2:0]  rm_i;
  logic [4:0]  rd_i;
  logic [9:0]  num1_exp;
  logic [47:0] num1_mant;
  logic        num1_sign, num1_is_NaN, num1_is_inf, num1_is_zero;
  logic [31:0] num2;
  logic        add_sub;
  logic [2:0]  rm_o;
  logic [4:0]  rd_o;
  logic        p_result, invalid;
  logic [4:0]  uu_rd [0:1];

  int checks = 0;
  int failures = 0;

  fmul_front_r4 dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .p_start(p_start),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .fma_op(fma_op),
    .rm_i(rm_i), .rd_i(rd_i),
    .num1_exp(num1_exp), .num1_mant(num1_mant), .num1_sign(num1_sign),
    .num1_is_NaN(num1_is_NaN), .num1_is_inf(num1_is_inf),
    .num1_is_zero(num1_is_zero), .num2(num2), .add_sub(add_sub),
    .rm_o(rm_o), .rd_o(rd_o), .p_result(p_result), .invalid(invalid),
    .uu_rd(uu_rd)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [1:0] f,
                               input logic [2:0] rm, input logic [4:0] rd,
                               input logic start);
    op_a = a; op_b = b; op_c = c; fma_op = f; rm_i = rm; rd_i = rd;
    p_start = start;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and let it reach the S2 outputs
  task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [1:0] f,
                       input logic [2:0] rm, input logic [4:0] rd);
    applyStimulus(a, b, c, f, rm, rd, 1'b1);
    tick();
    p_start = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clear = 2'b00;
    applyStimulus(32'h0, 32'h0, 32'h0, 2'b00, 3'd0, 5'd0, 1'b0);
    #2;
    checkOutput("reset_p_result", {63'd0, p_result}, 64'd0);
    checkOutput("reset_mant", {16'd0, num1_mant}, 64'd0);
    checkOutput("reset_rd_o", {59'd0, rd_o}, 64'd0);
    tick();
    rst = 1'b0; en = 1'b1;
    $display("[TB] basic multiply");

    // 1.5 * 2.0 : exp 127+128-127 = 128, sig 0xC00000*0x800000
    applyStimulus(32'h3FC00000, 32'h40000000, 32'h12345678, 2'b00, 3'd2, 5'd5, 1'b1);
    tick();
    checkOutput("s1_p_result_low", {63'd0, p_result}, 64'd0);
    checkOutput("s1_uu_rd0", {59'd0, uu_rd[0]}, 64'd5);
    p_start = 1'b0;
    tick();
    checkOutput("mul_p_result", {63'd0, p_result}, 64'd1);
    checkOutput("mul_exp", {54'd0, num1_exp}, 64'd128);
    checkOutput("mul_mant", {16'd0, num1_mant}, 64'h600000000000);
    checkOutput("mul_sign", {63'd0, num1_sign}, 64'd0);
    checkOutput("mul_add_sub", {63'd0, add_sub}, 64'd0);
    checkOutput("mul_num2", {32'd0, num2}, 64'h12345678);
    checkOutput("mul_rm_o", {61'd0, rm_o}, 64'd2);
    checkOutput("mul_rd_o", {59'd0, rd_o}, 64'd5);
    checkOutput("mul_uu_rd1", {59'd0, uu_rd[1]}, 64'd5);
    checkOutput("mul_zero", {63'd0, num1_is_zero}, 64'd0);

    // Stall three cycles with new inputs present, then flush S2
    en = 1'b0;
    applyStimulus(32'h40400000, 32'h40400000, 32'h0, 2'b11, 3'd1, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_p_result", {63'd0, p_result}, 64'd1);
      checkOutput("stall_mant", {16'd0, num1_mant}, 64'h600000000000);
      checkOutput("stall_rd_o", {59'd0, rd_o}, 64'd5);
    end
    p_start = 1'b0;
    en = 1'b1; clear = 2'b10;
    tick();
    clear = 2'b00;
    checkOutput("flush_p_result", {63'd0, p_result}, 64'd0);
    checkOutput("flush_mant", {16'd0, num1_mant}, 64'd0);
    checkOutput("flush_rd_o", {59'd0, rd_o}, 64'd0);

    $display("[TB] special operands");
    // inf * 0 under fnmadd
    runOp(32'h7F800000, 32'h00000000, 32'h0, 2'b11, 3'd0, 5'd7);
    checkOutput("inv_nan", {63'd0, num1_is_NaN}, 64'd1);
    checkOutput("inv_invalid", {63'd0, invalid}, 64'd1);
    checkOutput("inv_inf", {63'd0, num1_is_inf}, 64'd0);
    checkOutput("inv_zero", {63'd0, num1_is_zero}, 64'd0);
    checkOutput("inv_add_sub", {63'd0, add_sub}, 64'd1);
    checkOutput("inv_sign", {63'd0, num1_sign}, 64'd1);

    // -inf * 2.0
    runOp(32'hFF800000, 32'h40000000, 32'h0, 2'b00, 3'd0, 5'd8);
    checkOutput("inf_inf", {63'd0, num1_is_inf}, 64'd1);
    checkOutput("inf_nan", {63'd0, num1_is_NaN}, 64'd0);
    checkOutput("inf_invalid", {63'd0, invalid}, 64'd0);
    checkOutput("inf_sign", {63'd0, num1_sign}, 64'd1);

    // qNaN * 1.0
    runOp(32'h7FC00000, 32'h3F800000, 32'h0, 2'b00, 3'd0, 5'd8);
    checkOutput("nan_nan", {63'd0, num1_is_NaN}, 64'd1);
    checkOutput("nan_invalid", {63'd0, invalid}, 64'd0);
    checkOutput("nan_inf", {63'd0, num1_is_inf}, 64'd0);

    // -0 * 3.0 under fnmsub: sign 1^0^1 = 0, forced-zero fields
    runOp(32'h80000000, 32'h40400000, 32'h0, 2'b10, 3'd0, 5'd8);
    checkOutput("zero_zero", {63'd0, num1_is_zero}, 64'd1);
    checkOutput("zero_mant", {16'd0, num1_mant}, 64'd0);
    checkOutput("zero_exp", {54'd0, num1_exp}, 64'd0);
    checkOutput("zero_sign", {63'd0, num1_sign}, 64'd0);

    // smallest subnormal * 1.0
    runOp(32'h00000001, 32'h3F800000, 32'h0, 2'b00, 3'd0, 5'd8);
`ifdef FMUL_FRONT_SUBNORM_EN
    checkOutput("sub_zero", {63'd0, num1_is_zero}, 64'd0);
    checkOutput("sub_exp", {54'd0, num1_exp}, 64'd1);
    checkOutput("sub_mant", {16'd0, num1_mant}, 64'h000000800000);
`else
    checkOutput("sub_zero", {63'd0, num1_is_zero}, 64'd1);
    checkOutput("sub_exp", {54'd0, num1_exp}, 64'd0);
    checkOutput("sub_mant", {16'd0, num1_mant}, 64'd0);
`endif

    // -3.0 * 5.0 under fmsub: exp 128+129-127 = 130, sig 0xC00000*0xA00000
    runOp(32'hC0400000, 32'h40A00000, 32'h0, 2'b01, 3'd4, 5'd3);
    checkOutput("neg_exp", {54'd0, num1_exp}, 64'd130);
    checkOutput("neg_mant", {16'd0, num1_mant}, 64'h780000000000);
    checkOutput("neg_sign", {63'd0, num1_sign}, 64'd1);
    checkOutput("neg_add_sub", {63'd0, add_sub}, 64'd1);
    checkOutput("neg_rm_o", {61'd0, rm_o}, 64'd4);

    $display("[TB] streaming");
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(32'h3FC00000, 32'h40000000, 32'h0, 2'b00, 3'd0, 5'(k), 1'b1);
      tick();
      checkOutput("stream_uu_rd0", {59'd0, uu_rd[0]}, 64'(k));
      if (k >= 2) begin
        checkOutput("stream_p_result", {63'd0, p_result}, 64'd1);
        checkOutput("stream_rd_o", {59'd0, rd_o}, 64'(k - 1));
        checkOutput("stream_uu_rd1", {59'd0, uu_rd[1]}, 64'(k - 1));
      end
    end
    p_start = 1'b0;
    tick();
    checkOutput("stream_last_p", {63'd0, p_result}, 64'd1);
    checkOutput("stream_last_rd", {59'd0, rd_o}, 64'd4);
    tick();
    checkOutput("stream_end_p", {63'd0, p_result}, 64'd0);

    // clear[0] alongside p_start drops the operation
    applyStimulus(32'h3FC00000, 32'h40000000, 32'h0, 2'b00, 3'd0, 5'd20, 1'b1);
    clear = 2'b01;
    tick();
    clear = 2'b00; p_start = 1'b0;
    checkOutput("drop_uu_rd0", {59'd0, uu_rd[0]}, 64'd0);
    tick();
    checkOutput("drop_p_result", {63'd0, p_result}, 64'd0);
    checkOutput("drop_rd_o", {59'd0, rd_o}, 64'd0);

    $display("[TB] reset mid-flight");
    applyStimulus(32'h3FC00000, 32'h40000000, 32'h0, 2'b00, 3'd0, 5'd9, 1'b1);
    tick();
    rd_i = 5'd10;
    tick();
    p_start = 1'b0;
    checkOutput("pre_rst_p_result", {63'd0, p_result}, 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_p", {63'd0, p_result}, 64'd0);
    checkOutput("rst_async_rd_o", {59'd0, rd_o}, 64'd0);
    checkOutput("rst_async_uu_rd0", {59'd0, uu_rd[0]}, 64'd0);
    checkOutput("rst_async_mant", {16'd0, num1_mant}, 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("post_rst_idle_p", {63'd0, p_result}, 64'd0);
    end
    runOp(32'h3FC00000, 32'h40000000, 32'h0, 2'b00, 3'd0, 5'd11);
    checkOutput("post_rst_p", {63'd0, p_result}, 64'd1);
    checkOutput("post_rst_rd_o", {59'd0, rd_o}, 64'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmul_front_r4.md
FMUL_FRONT_R4 -- requirements
Module: fmul_front_r4

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk (rising edge) and rst (active-high, asynchronous).
REQ-002 clk  in  1  pipeline clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 en  in  1  advance enable; 0 holds all stages.
REQ-005 clear  in  2  per-stage flush; bit0 = stage S1, bit1 = stage S2.
REQ-006 p_start  in  1  operation-valid strobe for the inputs sampled this cycle.
REQ-007 op_a, op_b, op_c  in  32 each  IEEE-754 single operands; the result is a*b ± c.
REQ-008 fma_op  in  2  00 fmadd, 01 fmsub, 10 fnmsub, 11 fnmadd.
REQ-009 rm_i  in  3  rounding mode; rd_i  in  5  destination register.
REQ-010 num1_exp  out  10  biased product exponent, two's complement.
REQ-011 num1_mant  out  48  24x24 significand product; bits 47:46 are integer bits.
REQ-012 num1_sign, num1_is_NaN, num1_is_inf, num1_is_zero  out  1 each  product sign and class.
REQ-013 num2  out  32  op_c passed through unchanged; add_sub  out  1  (0 add, 1 subtract); rm_o  out  3; rd_o  out  5.
REQ-014 p_result  out  1  output-valid; invalid  out  1  inf*0 detected; uu_rd[0:1]  out  5 each  rd held in S1 and S2.

Function
REQ-015 The pipeline SHALL have two register stages, S1 (decode/class) and S2 (product), so the outputs are valid exactly 2 enabled cycles after p_start.
REQ-016 S1 SHALL register the sign, the 8-bit exponent, and the 24-bit significand with the hidden bit 1 for normals, plus the NaN/inf/zero/subnormal class of a and b, together with op_c, fma_op, rm_i, rd_i and p_start.
REQ-017 S2 SHALL register num1_mant = sig_a*sig_b.
REQ-018 S2 SHALL register num1_exp = ea_eff + eb_eff - 127, computed in 10-bit signed arithmetic with no saturation.
REQ-019 num1_sign SHALL be sa XOR sb XOR fma_op[1].
REQ-020 add_sub SHALL be fma_op[0].
REQ-021 num1_is_NaN SHALL be 1 if a or b is NaN, or if the operation is inf*0; invalid SHALL be 1 only for inf*0.
REQ-022 num1_is_inf SHALL be 1 if a or b is inf and num1_is_NaN is 0.
REQ-023 num1_is_zero SHALL be 1 if a or b is zero and neither num1_is_NaN nor num1_is_inf is set.
REQ-024 When num1_is_zero is 1, num1_mant and num1_exp SHALL be 0.
REQ-025 Control priority SHALL be: rst, then clear, then en.
REQ-026 With any clear bit set, each stage whose bit is set SHALL load zeros, and the other stages SHALL shift if en is 1 and hold if en is 0.
REQ-027 With en=0 and clear=0, all registers including p_result SHALL hold their values.
REQ-028 clear[0] together with p_start SHALL drop that operation.
REQ-029 clear[1] SHALL kill the operation in S2 while the S1 operation still advances to the outputs if en is 1.
REQ-030 Back-to-back p_start SHALL sustain throughput of one operation per enabled cycle.

Reset
REQ-031 On rst, all stage registers and all outputs SHALL go to 0 immediately, independent of clk.
REQ-032 An operation in flight during rst SHALL be discarded; the first valid result after rst is deasserted SHALL appear 2 enabled cycles after the next p_start.

Configuration
REQ-033 With FMUL_FRONT_SUBNORM_EN defined, subnormal inputs SHALL use hidden bit 0 and ea_eff = 1.
REQ-034 Without FMUL_FRONT_SUBNORM_EN, subnormal inputs SHALL be treated as zero of the same sign, which sets num1_is_zero accordingly.

Verification
REQ-035 Basic multiply: a=0x3FC00000, b=0x40000000, fma_op=00, p_start=1 with en=1 -> 2 cycles later p_result=1, num1_exp=128, num1_mant=0x600000000000, num1_sign=0, add_sub=0.
REQ-036 Invalid product: a=0x7F800000, b=0x00000000, fma_op=11 -> num1_is_NaN=1, invalid=1, num1_is_inf=0, add_sub=1, num1_sign=1.
REQ-037 Stall and flush: issue scenario REQ-035, then hold en=0 for 3 cycles -> outputs and p_result stable; then pulse clear[1] while the operation is in S2 -> p_result=0 and num1_mant=0.
REQ-038 Reset mid-flight: assert rst one cycle after p_start -> all outputs 0 asynchronously and p_result never rises for that operation.
REQ-039 Subnormal input: a=0x00000001, b=0x3F800000 -> with FMUL_FRONT_SUBNORM_EN: num1_is_zero=0, num1_exp=1, num1_mant=0x000000800000; without it: num1_is_zero=1.
REQ-040 Streaming: 4 back-to-back p_start with distinct rd_i -> 4 consecutive p_result pulses in issue order, with rd_o matching and uu_rd[0]/uu_rd[1] tracking S1/S2.
